hack_rom_loader: RTL and testbench
==================================

Name: hack_rom_loader

Overview:
Instruction-ROM stage that sits directly upstream of the CPU. It holds the program memory and drives the CPU's instruction input combinationally from the CPU program counter. A byte-stream boot protocol, fed by a UART receiver, writes the memory. The CPU is held in reset until a complete image with a valid checksum has been loaded.

Parameters:
ROM_AW, 15, ROM address width; depth = 2**ROM_AW 16-bit words.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
rx_valid  input  1  byte strobe from the UART receiver; a byte is accepted on any rising edge where rx_valid=1.
rx_data  input  8  received byte, qualified by rx_valid.
pc  input  16  CPU program counter.
inst  output  16  instruction word to the CPU; equals rom[pc[ROM_AW-1:0]].
cpu_reset  output  1  active-high reset to the CPU; registered.
loading  output  1  high while a load is in progress (states LEN_HI through CSUM).
error  output  1  high in state ERROR.
words_loaded  output  16  count of words written in the current or last load.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cpu_reset=1, error=0, loading=0, words_loaded=0.
  - Internal length register, write address, high-byte latch and checksum accumulator all clear to 0.
  - ROM contents are not cleared. Reset mid-load leaves the partially written words in place.
- ROM read:
  - Asynchronous (combinational) read: inst = rom[pc[ROM_AW-1:0]].
  - pc bits above ROM_AW-1 are ignored, so addresses wrap.
  - A word written on edge k is visible on inst after edge k.
- Byte acceptance: at most one byte per cycle. No backpressure; the loader is always ready.
- Protocol: 0xA5, LEN_H, LEN_L, then 2*N data bytes (each word MSB first), then CSUM.
  - N = {LEN_H, LEN_L} is a count of 16-bit words.
  - CSUM = XOR of all 2*N data bytes. Header and length bytes are excluded.
- States and transitions (all on accepted bytes unless noted):
  - IDLE: 0xA5 -> LEN_HI; clear checksum, write address and words_loaded. Any other byte is ignored.
  - LEN_HI: latch LEN_H -> LEN_LO.
  - LEN_LO: latch LEN_L, then:
    - if N > 2**ROM_AW -> ERROR;
    - else if N = 0 -> CSUM;
    - else -> DATA_HI.
  - DATA_HI: latch byte as the high half, XOR it into the checksum -> DATA_LO.
  - DATA_LO: XOR byte into the checksum; write rom[wr_addr] <= {hi, byte}; increment wr_addr and words_loaded.
    - if wr_addr+1 = N -> CSUM;
    - else -> DATA_HI.
  - CSUM: byte == accumulator -> RUN; otherwise -> ERROR.
  - RUN: 0xA5 -> LEN_HI (restarts a load, clears counters). Other bytes are ignored.
  - ERROR: 0xA5 -> LEN_HI and error clears. Other bytes are ignored.
- Output timing:
  - cpu_reset = (next_state != RUN), registered. It falls in the cycle after the edge that accepts a correct CSUM byte. It rises in the cycle after the edge that accepts 0xA5 in RUN.
  - loading and error are registered decodes of state.
- No timeout on an idle byte stream: the loader waits indefinitely in any state.
- words_loaded holds its value in RUN and ERROR until the next 0xA5 is accepted.
- A gap cycle (rx_valid=0) between bytes changes nothing.

Test Plan:
1. Good load: reset, then bytes A5 00 02 00 05 EC 10 F9 on consecutive cycles.
   -> cpu_reset=0 one cycle after F9; words_loaded=2; pc=0 -> inst=0x0005; pc=1 -> inst=0xEC10; pc=0x8001 -> inst=0xEC10 (wrap, ROM_AW=15).
2. Bad checksum: A5 00 02 00 05 EC 10 00.
   -> error=1, cpu_reset=1, loading=0. Then the good stream from test 1 -> error=0, cpu_reset=0.
3. Oversize length with ROM_AW=4: A5 00 11.
   -> ERROR after the third byte; words_loaded=0; a subsequent non-A5 byte leaves error=1.
4. Zero length: A5 00 00 00.
   -> RUN, words_loaded=0, ROM unchanged. With A5 00 00 01 instead -> ERROR.
5. Reload from RUN: after test 1, send A5.
   -> cpu_reset=1 the next cycle, loading=1, words_loaded=0. Then 00 01 12 34 26 -> RUN with inst(pc=0)=0x1234 and inst(pc=1)=0xEC10 (retained).
6. Async reset mid-load: assert reset=0 between data bytes (not aligned to clk).
   -> immediate state=IDLE, cpu_reset=1, loading=0. Already written words remain readable on inst; a byte 0x00 after release is ignored.

Source files
------------

// File: rtl/hack_rom_loader.sv
// hack_rom_loader: instruction ROM written by a checksummed byte-stream boot protocol;
// holds the CPU in reset until a complete, valid image has been loaded.
module hack_rom_loader #(
    parameter int ROM_AW = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic [15:0] pc,
    output logic [15:0] inst,
    output logic        cpu_reset,
    output logic        loading,
    output logic        error,
    output logic [15:0] words_loaded
);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, RUN, ERROR} state_t;
    localparam logic [16:0] DEPTH = 17'd1 << ROM_AW;
    state_t state, state_n;
    logic [15:0] len, count;
    logic [7:0] hi, csum;
    logic [15:0] rom [2**ROM_AW];
    logic start, wr, unused_pc;
    assign inst = rom[pc[ROM_AW-1:0]];
    assign unused_pc = &{1'b0, pc};
    // write address and words_loaded always move together, so one counter serves both
    assign words_loaded = count;
    assign start = rx_valid && rx_data == 8'hA5 && (state == IDLE || state == RUN || state == ERROR);
    assign wr = rx_valid && state == DATA_LO;
    always_comb begin
        state_n = state;
        if (rx_valid) begin
            case (state)
                IDLE, RUN, ERROR: state_n = (rx_data == 8'hA5) ? LEN_HI : state;
                LEN_HI:  state_n = LEN_LO;
                LEN_LO:  state_n = ({1'b0, len[15:8], rx_data} > DEPTH) ? ERROR :
                                   ({len[15:8], rx_data} == 16'd0) ? CSUM : DATA_HI;
                DATA_HI: state_n = DATA_LO;
                DATA_LO: state_n = (count + 16'd1 == len) ? CSUM : DATA_HI;
                CSUM:    state_n = (rx_data == csum) ? RUN : ERROR;
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            len       <= '0;
            count     <= '0;
            hi        <= '0;
            csum      <= '0;
            cpu_reset <= 1'b1;
            loading   <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            cpu_reset <= state_n != RUN;
            loading   <= state_n inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM};
            error     <= state_n == ERROR;
            if (start) begin
                count <= '0;
                csum  <= '0;
            end
            if (rx_valid && state == LEN_HI) len[15:8] <= rx_data;
            if (rx_valid && state == LEN_LO) len[7:0] <= rx_data;
            if (rx_valid && state == DATA_HI) begin
                hi   <= rx_data;
                csum <= csum ^ rx_data;
            end
            if (wr) begin
                csum  <= csum ^ rx_data;
                count <= count + 16'd1;
            end
        end
    end
    // program memory survives reset so a partial image stays readable
    always_ff @(posedge clk) begin
        if (wr) rom[count[ROM_AW-1:0]] <= {hi, rx_data};
    end
endmodule

// File: tb/tb_hack_rom_loader.sv
// tb_hack_rom_loader: directed and randomized boot streams checked against a
// frame-position model of the loader protocol.
module tb_hack_rom_loader;
    localparam int AW = 15;
    localparam int DEPTH = 1 << AW;
    logic clk = 0, reset = 1, rx_valid = 0;
    logic [7:0] rx_data = 0;
    logic [15:0] pc = 0;
    logic [15:0] inst, words_loaded;
    logic cpu_reset, loading, error;
    int checks = 0, errors = 0;

    hack_rom_loader #(.ROM_AW(AW)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .pc(pc),
        .inst(inst), .cpu_reset(cpu_reset), .loading(loading), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    bit m_active = 0, m_run = 0, m_err = 0;
    int m_idx = 0, m_n = 0, m_words = 0;
    logic [7:0] m_x, m_hi, m_lh;
    logic [15:0] m_rom [DEPTH];
    bit m_valid [DEPTH];

    // model tracks the byte position within the current frame
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 0; m_run = 0; m_err = 0; m_words = 0;
        end else if (rx_valid) begin
            if (!m_active) begin
                if (rx_data == 8'hA5) begin
                    m_active = 1; m_run = 0; m_err = 0; m_idx = 0; m_x = 0; m_words = 0;
                end
            end else begin
                m_idx++;
                if (m_idx == 1) m_lh = rx_data;
                else if (m_idx == 2) begin
                    m_n = int'({m_lh, rx_data});
                    if (m_n > DEPTH) begin m_active = 0; m_err = 1; end
                end else if (m_idx <= 2 * m_n + 2) begin
                    m_x ^= rx_data;
                    if (m_idx % 2 == 1) m_hi = rx_data;
                    else begin
                        m_rom[m_words] = {m_hi, rx_data};
                        m_valid[m_words] = 1;
                        m_words++;
                    end
                end else begin
                    m_active = 0; m_run = (rx_data == m_x); m_err = !m_run;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cpu_reset", 32'(cpu_reset), 32'(!m_run));
        chk("loading", 32'(loading), 32'(m_active));
        chk("error", 32'(error), 32'(m_err));
        chk("words_loaded", 32'(words_loaded), 32'(m_words));
        if (m_valid[pc[AW-1:0]]) chk("inst", 32'(inst), 32'(m_rom[pc[AW-1:0]]));
    end

    task automatic send(input logic [7:0] b);
        rx_valid = 1;
        rx_data = b;
        pc = {1'($urandom_range(0, 1)), 12'd0, 3'($urandom_range(0, 7))};
        @(posedge clk);
        #1 rx_valid = 0;
    endtask

    task automatic sendv(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send(v[8*i +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic peek(input string name, input logic [15:0] a, input logic [15:0] exp);
        pc = a;
        #1 chk(name, 32'(inst), 32'(exp));
    endtask

    initial begin
        logic [7:0] x, b;
        int n;
        #1 reset = 0;
        idle(2);
        #2 reset = 1;
        idle(1);
        chk("rst_cpu_reset", 32'(cpu_reset), 1);
        chk("rst_loading", 32'(loading), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_words", 32'(words_loaded), 0);
        // good load
        sendv(64'h00A5_0002_0005_EC10, 7);
        chk("t1_pre_csum", 32'(cpu_reset), 1);
        send(8'hF9);
        chk("t1_cpu_reset", 32'(cpu_reset), 0);
        chk("t1_words", 32'(words_loaded), 2);
        peek("t1_inst0", 16'h0000, 16'h0005);
        peek("t1_inst1", 16'h0001, 16'hEC10);
        peek("t1_wrap", 16'h8001, 16'hEC10);
        // reload from RUN
        send(8'hA5);
        chk("t5_cpu_reset", 32'(cpu_reset), 1);
        chk("t5_loading", 32'(loading), 1);
        chk("t5_words", 32'(words_loaded), 0);
        sendv(64'h0001_1234_26, 5);
        chk("t5_run", 32'(cpu_reset), 0);
        peek("t5_inst0", 16'h0000, 16'h1234);
        peek("t5_inst1", 16'h0001, 16'hEC10);
        // bad checksum then recovery
        sendv(64'hA500_0200_05EC_1000, 8);
        chk("t2_error", 32'(error), 1);
        chk("t2_cpu_reset", 32'(cpu_reset), 1);
        chk("t2_loading", 32'(loading), 0);
        sendv(64'hA500_0200_05EC_10F9, 8);
        chk("t2_error_clr", 32'(error), 0);
        chk("t2_cpu_run", 32'(cpu_reset), 0);
        // oversize length
        sendv(64'hA58001, 3);
        chk("t3_error", 32'(error), 1);
        chk("t3_words", 32'(words_loaded), 0);
        send(8'h00);
        chk("t3_sticky", 32'(error), 1);
        sendv(64'hA5FFFF, 3);
        chk("t3_ffff", 32'(error), 1);
        // zero length
        sendv(64'hA5000000, 4);
        chk("t4_run", 32'(cpu_reset), 0);
        chk("t4_words", 32'(words_loaded), 0);
        peek("t4_inst0", 16'h0000, 16'h0005);
        sendv(64'hA5000001, 4);
        chk("t4_error", 32'(error), 1);
        // async reset mid-load
        sendv(64'hA5_0003_AABB_CC, 6);
        #3 reset = 0;
        #1;
        chk("t6_cpu_reset", 32'(cpu_reset), 1);
        chk("t6_loading", 32'(loading), 0);
        #7 reset = 1;
        idle(1);
        peek("t6_inst0", 16'h0000, 16'hAABB);
        send(8'h00);
        chk("t6_ignored", 32'(loading), 0);
        chk("t6_idle_cpu", 32'(cpu_reset), 1);
        // randomized frames with gaps, junk and bad checksums
        repeat (150) begin
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom_range(0, 255));
                send(b == 8'hA5 ? 8'h00 : b);
            end
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH + 1, 65535) : $urandom_range(0, 6);
            send(8'hA5);
            send(8'(n >> 8));
            send(8'(n));
            if (n <= DEPTH) begin
                x = 0;
                for (int i = 0; i < 2 * n; i++) begin
                    b = 8'($urandom);
                    x ^= b;
                    send(b);
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                send(($urandom_range(0, 4) == 0) ? x ^ 8'($urandom_range(1, 255)) : x);
            end
            idle($urandom_range(0, 2));
        end
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
